instruction_encoder: RTL and testbench

//  Inverse of the instruction decoder: packs R/I/J field tuples into 32-bit words for instruction-memory loading.

---
 rtl/instruction_encoder_pkg.sv | 48 ++++
 rtl/instruction_encoder_fifo.sv | 36 +++
 rtl/instruction_encoder.sv | 86 ++++++++
 tb/tb_instruction_encoder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/instruction_encoder_pkg.sv
// instruction_encoder_pkg: format codes, field positions, FSM states and the tuple packer
package instruction_encoder_pkg;
  localparam logic [1:0] FMT_R = 2'b00;
  localparam logic [1:0] FMT_I = 2'b01;
  localparam logic [1:0] FMT_J = 2'b10;
  localparam logic [1:0] FMT_BAD = 2'b11;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int SH_HI = 15;
  localparam int SH_LO = 11;
  localparam int FUNC_HI = 4;
  localparam int FUNC_LO = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int LBL_HI = 25;
  localparam int LBL_LO = 0;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
  // Fields not belonging to the format are left zero; an illegal format packs to all zeros.
  function automatic logic [31:0] pack(
    input logic [1:0] f,
    input logic [5:0] op,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] sh,
    input logic [4:0] fn,
    input logic [15:0] imm,
    input logic [25:0] lbl
  );
    logic [31:0] w;
    w = '0;
    if (f != FMT_BAD) w[OPC_HI:OPC_LO] = op;
    if (f == FMT_R || f == FMT_I) begin
      w[RS_HI:RS_LO] = rs;
      w[RT_HI:RT_LO] = rt;
    end
    if (f == FMT_R) begin
      w[SH_HI:SH_LO] = sh;
      w[FUNC_HI:FUNC_LO] = fn;
    end
    if (f == FMT_I) w[IMM_HI:IMM_LO] = imm;
    if (f == FMT_J) w[LBL_HI:LBL_LO] = lbl;
    return w;
  endfunction
endpackage

// File: rtl/instruction_encoder_fifo.sv
// instr_fifo: DEPTH-entry synchronous FIFO with registered full/empty
//   push/din write the tail, pop/dout consume the head, dout reads zero while empty
module instr_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = wr_q == rd_q;
  assign full = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push && !full) begin
        mem_q[wr_q[AW-1:0]] <= din;
        wr_q <= wr_q + 1'b1;
      end
      if (pop && !empty) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs R/I/J field tuples into {word, address} pairs over a counted load session
//   start/base_addr/num_instr open a session; in_valid/in_ready accept tuples;
//   out_valid/out_ready/out_word/out_addr drain the FIFO; busy/done/err report session status
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ADDR_STEP = 4,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        shamt,
  input  logic [4:0]        func,
  input  logic [15:0]       imm,
  input  logic [25:0]       label,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_e state_q;
  logic [ADDR_W-1:0] addr_q, remain_q;
  logic err_q, push, pop, full, empty;
  logic [31:0] word;
  logic [31+ADDR_W:0] head;
  assign word = pack(fmt, opcode, rs, rt, shamt, func, imm, label);
  // Full is the registered flag: a pop in the same cycle does not free a slot for the push.
  assign in_ready = state_q == LOAD && remain_q != '0 && !full;
  assign push = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  assign {out_word, out_addr} = head;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err = err_q;
  instr_fifo #(.W(32 + ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din({word, addr_q}),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      remain_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          addr_q <= base_addr;
          remain_q <= num_instr;
          err_q <= 1'b0;
          state_q <= num_instr == '0 ? DONE : LOAD;
        end
        LOAD: begin
          if (push) begin
            addr_q <= addr_q + ADDR_W'(ADDR_STEP);
            remain_q <= remain_q - 1'b1;
            if (fmt == FMT_BAD) err_q <= 1'b1;
          end
          // Session ends only once every accepted word has left the FIFO.
          if (remain_q == '0 && empty) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed vectors with hand-computed words and addresses
module tb_instruction_encoder;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] base_addr = '0, num_instr = '0, out_addr, out_word;
  logic in_ready, out_valid, busy, done, err;
  logic [1:0] fmt = '0;
  logic [5:0] opcode = '0;
  logic [4:0] rs = '0, rt = '0, shamt = '0, func = '0;
  logic [15:0] imm = '0;
  logic [25:0] label = '0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  instruction_encoder dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_instr(num_instr),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt),
    .shamt(shamt), .func(func), .imm(imm), .label(label), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr), .busy(busy),
    .done(done), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic [1:0] f, input logic [5:0] op, input logic [4:0] a, input logic [4:0] b,
                     input logic [4:0] c, input logic [4:0] d, input logic [15:0] im, input logic [25:0] lb);
    fmt = f; opcode = op; rs = a; rt = b; shamt = c; func = d; imm = im; label = lb;
    in_valid = 1'b1;
  endtask
  task automatic send(input string tag);
    chk({tag, "_rdy"}, {31'b0, in_ready}, 1);
    tick();
    in_valid = 1'b0;
  endtask
  task automatic head(input string tag, input logic [31:0] w, input logic [31:0] a);
    chk({tag, "_ov"}, {31'b0, out_valid}, 1);
    chk({tag, "_word"}, out_word, w);
    chk({tag, "_addr"}, out_addr, a);
  endtask
  task automatic begin_session(input logic [31:0] b, input logic [31:0] n);
    base_addr = b; num_instr = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic finish_session(input string tag);
    chk({tag, "_ov0"}, {31'b0, out_valid}, 0);
    chk({tag, "_nodone"}, {31'b0, done}, 0);
    tick();
    chk({tag, "_done"}, {31'b0, done}, 1);
    tick();
    chk({tag, "_done0"}, {31'b0, done}, 0);
    chk({tag, "_idle"}, {31'b0, busy}, 0);
  endtask
  initial begin
    tick(); tick();
    chk("rst_ir", {31'b0, in_ready}, 0);
    chk("rst_ov", {31'b0, out_valid}, 0);
    chk("rst_word", out_word, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    rst = 1'b0;
    drv(2'b00, 6'd9, 5'd9, 5'd9, 5'd9, 5'd9, 16'h1111, 26'h1);
    tick();
    chk("idle_drop", {31'b0, out_valid}, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    begin_session(32'h100, 32'd3);
    chk("s1_busy", {31'b0, busy}, 1);
    drv(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd5, 16'hABCD, 26'h2AAAAAA);
    send("s1_r");
    head("s1_r", 32'h0022_1805, 32'h100);
    chk("s1_dec_rs", {27'b0, out_word[25:21]}, 1);
    chk("s1_dec_rt", {27'b0, out_word[20:16]}, 2);
    chk("s1_dec_sh", {27'b0, out_word[15:11]}, 3);
    chk("s1_dec_fn", {27'b0, out_word[4:0]}, 5);
    drv(2'b01, 6'd8, 5'd3, 5'd4, 5'd31, 5'd31, 16'hFFFF, 26'h1555555);
    send("s1_i");
    head("s1_i", 32'h2064_FFFF, 32'h104);
    drv(2'b10, 6'd2, 5'd7, 5'd7, 5'd7, 5'd7, 16'h5555, 26'h3FFFFFF);
    send("s1_j");
    head("s1_j", 32'h0BFF_FFFF, 32'h108);
    chk("s1_ir0", {31'b0, in_ready}, 0);
    tick();
    finish_session("s1");
    chk("s1_err", {31'b0, err}, 0);
    out_ready = 1'b0;
    begin_session(32'h200, 32'd3);
    drv(2'b00, 6'h3F, 5'd31, 5'd0, 5'h1F, 5'h1F, 16'hFFFF, 26'h3FFFFFF);
    send("bp_t1");
    drv(2'b01, 6'h23, 5'd2, 5'd5, 5'd17, 5'd9, 16'h1234, 26'h0);
    send("bp_t2");
    drv(2'b10, 6'd3, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h0123456);
    chk("bp_full", {31'b0, in_ready}, 0);
    head("bp_h0", 32'hFFE0_F81F, 32'h200);
    tick();
    head("bp_h1", 32'hFFE0_F81F, 32'h200);
    chk("bp_full1", {31'b0, in_ready}, 0);
    out_ready = 1'b1;
    chk("bp_nocredit", {31'b0, in_ready}, 0);
    tick();
    head("bp_t2", 32'h8C45_1234, 32'h204);
    send("bp_t3");
    head("bp_t3", 32'h0C12_3456, 32'h208);
    tick();
    finish_session("bp");
    begin_session(32'h500, 32'd0);
    chk("z_done", {31'b0, done}, 1);
    chk("z_ov", {31'b0, out_valid}, 0);
    chk("z_ir", {31'b0, in_ready}, 0);
    tick();
    chk("z_done0", {31'b0, done}, 0);
    chk("z_idle", {31'b0, busy}, 0);
    begin_session(32'hFFFF_FFFC, 32'd2);
    drv(2'b11, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF);
    send("w_bad");
    head("w_bad", 32'h0, 32'hFFFF_FFFC);
    chk("w_err", {31'b0, err}, 1);
    drv(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0);
    send("w_r");
    head("w_r", 32'h0022_1805, 32'h0);
    tick();
    finish_session("w");
    chk("w_err_hold", {31'b0, err}, 1);
    out_ready = 1'b0;
    begin_session(32'h300, 32'd4);
    chk("m_err_clr", {31'b0, err}, 0);
    drv(2'b01, 6'd1, 5'd1, 5'd1, 5'd0, 5'd0, 16'h7, 26'h0);
    send("m_t1");
    head("m_t1", 32'h0421_0007, 32'h300);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("m_ov", {31'b0, out_valid}, 0);
    chk("m_busy", {31'b0, busy}, 0);
    chk("m_done", {31'b0, done}, 0);
    chk("m_ir", {31'b0, in_ready}, 0);
    tick();
    chk("m_nodone", {31'b0, done}, 0);
    out_ready = 1'b1;
    begin_session(32'h40, 32'd1);
    drv(2'b10, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
    send("m_new");
    head("m_new", 32'h0C00_0010, 32'h40);
    tick();
    finish_session("m");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
